// File: rtl/imem_shadow_if.sv
// Bus bundle for imem_shadow: backing sync-memory port plus the packed fetch read ports.
// Timing contract: bk_data_i carries mem[bk_addr_o] one cycle after the address is presented; no stalls.
interface imem_shadow_if #(
    parameter int A    = 6,
    parameter int W    = 32,
    parameter int N_RD = 2
);
    logic [A-1:0]      bk_addr_o;
    logic [W-1:0]      bk_data_i;
    logic [N_RD*A-1:0] rd_addr_i;
    logic [N_RD*W-1:0] rd_data_o;

    modport slave (
        output bk_addr_o,
        output rd_data_o,
        input  bk_data_i,
        input  rd_addr_i
    );

    modport master (
        input  bk_addr_o,
        input  rd_data_o,
        output bk_data_i,
        output rd_addr_i
    );
endinterface

// File: rtl/imem_shadow.sv
// Register-array shadow of a synchronous backing memory, refreshed by address scan,
// with N combinational read ports for the fetch path.
module imem_shadow #(
    parameter int A    = 6,
    parameter int W    = 32,
    parameter int N_RD = 2
) (
    input  logic                refresh_clk,
    input  logic                n_reset,
    input  logic                mode_i,
    input  logic                start_i,
    imem_shadow_if.slave        bus,
    output logic                busy_o,
    output logic                done_o,
    output logic                valid_o,
    output logic [7:0]          pass_cnt_o,
    output logic [1:0]          state_o
);
    localparam int DEPTH = 1 << A;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SCAN  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [A-1:0] LAST_ADDR = '1;

    logic [1:0]   state_q, state_d;
    logic [A-1:0] bk_addr_q, bk_addr_d;
    logic [A-1:0] cap_addr_q, cap_addr_d;
    logic         cap_en_q, cap_en_d;
    logic         done_q, done_d;
    logic         valid_q, valid_d;
    logic [7:0]   pass_cnt_q, pass_cnt_d;
    logic [W-1:0] shadow_q [DEPTH];
    logic [W-1:0] shadow_d [DEPTH];

    // Mode is only looked at in IDLE and on the last-address cycle, so a pass is never cut short.
    always_comb begin
        state_d   = state_q;
        bk_addr_d = bk_addr_q;
        case (state_q)
            S_IDLE: begin
                bk_addr_d = '0;
                if (!mode_i || start_i) state_d = S_SCAN;
            end
            S_SCAN: begin
                if (bk_addr_q == LAST_ADDR) begin
                    bk_addr_d = '0;
                    if (mode_i) state_d = S_DRAIN;
                end else begin
                    bk_addr_d = bk_addr_q + 1'b1;
                end
            end
            S_DRAIN: begin
                bk_addr_d = '0;
                state_d   = S_IDLE;
            end
            default: begin
                bk_addr_d = '0;
                state_d   = S_IDLE;
            end
        endcase
    end

    // Registering the issued address alongside the memory's own latency keeps data and address aligned.
    always_comb begin
        cap_en_d   = (state_q == S_SCAN);
        cap_addr_d = bk_addr_q;
        done_d     = cap_en_q && (cap_addr_q == LAST_ADDR);
        valid_d    = valid_q | done_d;
        pass_cnt_d = pass_cnt_q;
        if (done_d) pass_cnt_d = pass_cnt_q + 8'd1;
        for (int i = 0; i < DEPTH; i++) shadow_d[i] = shadow_q[i];
        if (cap_en_q) shadow_d[cap_addr_q] = bus.bk_data_i;
    end

    always_ff @(posedge refresh_clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q    <= S_IDLE;
            bk_addr_q  <= '0;
            cap_addr_q <= '0;
            cap_en_q   <= 1'b0;
            done_q     <= 1'b0;
            valid_q    <= 1'b0;
            pass_cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) shadow_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            bk_addr_q  <= bk_addr_d;
            cap_addr_q <= cap_addr_d;
            cap_en_q   <= cap_en_d;
            done_q     <= done_d;
            valid_q    <= valid_d;
            pass_cnt_q <= pass_cnt_d;
            for (int i = 0; i < DEPTH; i++) shadow_q[i] <= shadow_d[i];
        end
    end

    // Reads see the registered array only: a same-cycle write shows up on the following cycle.
    always_comb begin
        bus.rd_data_o = '0;
        for (int p = 0; p < N_RD; p++) begin
            bus.rd_data_o[p*W +: W] = shadow_q[bus.rd_addr_i[p*A +: A]];
        end
    end

    assign bus.bk_addr_o = bk_addr_q;
    assign busy_o        = (state_q != S_IDLE);
    assign done_o        = done_q;
    assign valid_o       = valid_q;
    assign pass_cnt_o    = pass_cnt_q;
    assign state_o       = state_q;
endmodule
